// File: rtl/qspi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : qspi_pkg                                                     |
// | Description : Shared definitions for the QSPI read-only flash requester:   |
// |               FSM state encoding, default read opcode, per-phase bit       |
// |               counts and the byte-order helper for returned words.         |
// | Ports       : none (package)                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package qspi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COMMAND = 3'd1,
    ST_ADDRESS = 3'd2,
    ST_DATA    = 3'd3,
    ST_CHECK   = 3'd4,
    ST_RELEASE = 3'd5
  } state_t;

  localparam logic [7:0] DEFAULT_READ_COMMAND = 8'h03;

  localparam int CMD_BITS  = 8;
  localparam int ADDR_BITS = 24;
  localparam int DATA_BITS = 32;

  // One counter serves every phase; it never needs to reach DATA_BITS.
  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_BITS - 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_BITS - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);

  // Flash streams bytes in ascending address order; the first byte received
  // lands in the top of the shift register but belongs in data[7:0].
  function automatic logic [31:0] byte_swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/qspi_device_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : qspi_device_if                                               |
// | Description : Word-read request bus between a client and qspi_device.      |
// | Signals     : dataRequest_address   [23:0] byte address (bits 1:0 unused)  |
// |               dataRequest_enable           level-sensitive request         |
// |               dataRequest_data      [31:0] returned word                   |
// |               dataRequest_dataValid        one-cycle data strobe           |
// | Modports    : master - client side, slave - qspi_device side               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface qspi_device_if;

  logic [23:0] dataRequest_address;
  logic        dataRequest_enable;
  logic [31:0] dataRequest_data;
  logic        dataRequest_dataValid;

  modport master (
    output dataRequest_address,
    output dataRequest_enable,
    input  dataRequest_data,
    input  dataRequest_dataValid
  );

  modport slave (
    input  dataRequest_address,
    input  dataRequest_enable,
    output dataRequest_data,
    output dataRequest_dataValid
  );

endinterface
`default_nettype wire

// File: rtl/qspi_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : qspi_shifter                                                 |
// | Description : SPI mode-0 bit engine. Each bit spans two clk cycles:        |
// |               phase A (sck=0, mosi presented) then phase B (sck=1); miso   |
// |               is captured on the clk edge that ends phase B.               |
// | Ports       : clk, rst          clock / synchronous active-high reset      |
// |               load, load_word   start a new transfer with a 32-bit header  |
// |               active            current cycle belongs to a bit             |
// |               miso              serial input from flash                    |
// |               sck, mosi         registered SPI outputs                     |
// |               bit_end           current cycle is phase B of a bit          |
// |               rx_next           receive register including the live miso   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module qspi_shifter (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        load,
  input  wire logic [31:0] load_word,
  input  wire logic        active,
  input  wire logic        miso,
  output logic             sck,
  output logic             mosi,
  output logic             bit_end,
  output logic [31:0]      rx_next
);

  logic        phase;   // 0: phase A, 1: phase B
  logic [31:0] tx_sr;
  logic [31:0] rx_sr;

  // Outputs are registered, so every decision here sets up the NEXT cycle.
  // Once the command+address header has been shifted out tx_sr is all zero,
  // which keeps mosi low for the whole data phase, including streamed words.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= 1'b0;
      sck   <= 1'b0;
      mosi  <= 1'b0;
      tx_sr <= '0;
      rx_sr <= '0;
    end else if (load) begin
      phase <= 1'b0;
      sck   <= 1'b0;
      mosi  <= load_word[31];
      tx_sr <= {load_word[30:0], 1'b0};
    end else if (active) begin
      if (!phase) begin
        phase <= 1'b1;
        sck   <= 1'b1;
      end else begin
        phase <= 1'b0;
        sck   <= 1'b0;
        mosi  <= tx_sr[31];
        tx_sr <= {tx_sr[30:0], 1'b0};
        rx_sr <= rx_next;
      end
    end
  end

  // phase only leaves 0 while active, so it alone marks the sampling cycle.
  assign bit_end = phase;
  assign rx_next = {rx_sr[30:0], miso};

endmodule
`default_nettype wire

// File: rtl/qspi_device.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : qspi_device                                                  |
// | Description : Serves 32-bit word reads from a SPI NOR flash using the      |
// |               single-bit READ command. Consecutive word requests presented |
// |               at the end of a read keep chip select low and stream on      |
// |               without resending command and address.                       |
// | Parameters  : CS_HIGH_CYCLES  clk cycles spent in RELEASE with csb high    |
// |               READ_COMMAND    read opcode, sent MSB first                  |
// | Ports       : clk, rst        clock / synchronous active-high reset        |
// |               req             qspi_device_if.slave request bus             |
// |               flash_csb       chip select, active low                      |
// |               flash_sck       SPI clock, mode 0                            |
// |               flash_mosi      serial data to flash                         |
// |               flash_miso      serial data from flash                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module qspi_device
  import qspi_pkg::*;
#(
  parameter int         CS_HIGH_CYCLES = 2,
  parameter logic [7:0] READ_COMMAND   = DEFAULT_READ_COMMAND
) (
  input  wire logic     clk,
  input  wire logic     rst,
  qspi_device_if.slave  req,
  output logic          flash_csb,
  output logic          flash_sck,
  output logic          flash_mosi,
  input  wire logic     flash_miso
);

  localparam int REL_W = (CS_HIGH_CYCLES > 1) ? $clog2(CS_HIGH_CYCLES) : 1;
  localparam logic [REL_W-1:0] REL_LAST = REL_W'(CS_HIGH_CYCLES - 1);

  state_t             state, state_n;
  logic [CNT_W-1:0]   bit_cnt, bit_cnt_n;
  logic [REL_W-1:0]   rel_cnt, rel_cnt_n;
  logic [21:0]        word_idx, word_idx_n;
  logic [21:0]        next_idx;
  logic [31:0]        data_q, data_n;
  logic               valid_q, valid_n;
  logic               csb_q, csb_n;

  logic               load;
  logic [31:0]        load_word;
  logic               active;
  logic               bit_end;
  logic [31:0]        rx_next;
  logic               unused_addr_lsbs;

  // Byte lanes inside a word are always fetched as a whole word.
  assign unused_addr_lsbs = ^req.dataRequest_address[1:0];

  // 22-bit arithmetic: the last word of the array streams into word 0.
  assign next_idx = word_idx + 22'd1;

  qspi_shifter u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_word (load_word),
    .active    (active),
    .miso      (flash_miso),
    .sck       (flash_sck),
    .mosi      (flash_mosi),
    .bit_end   (bit_end),
    .rx_next   (rx_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      rel_cnt  <= '0;
      word_idx <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      csb_q    <= 1'b1;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      rel_cnt  <= rel_cnt_n;
      word_idx <= word_idx_n;
      data_q   <= data_n;
      valid_q  <= valid_n;
      csb_q    <= csb_n;
    end
  end

  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    rel_cnt_n  = rel_cnt;
    word_idx_n = word_idx;
    data_n     = data_q;
    valid_n    = 1'b0;
    csb_n      = csb_q;
    load       = 1'b0;
    load_word  = '0;
    active     = 1'b0;

    unique case (state)
      ST_IDLE: begin
        csb_n = 1'b1;
        if (req.dataRequest_enable) begin
          // Command and address together fill exactly one 32-bit header.
          word_idx_n = req.dataRequest_address[23:2];
          load       = 1'b1;
          load_word  = {READ_COMMAND, req.dataRequest_address[23:2], 2'b00};
          csb_n      = 1'b0;
          bit_cnt_n  = '0;
          state_n    = ST_COMMAND;
        end
      end

      ST_COMMAND: begin
        active = 1'b1;
        if (bit_end) begin
          if (bit_cnt == CMD_LAST) begin
            bit_cnt_n = '0;
            state_n   = ST_ADDRESS;
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
          end
        end
      end

      ST_ADDRESS: begin
        active = 1'b1;
        if (bit_end) begin
          if (bit_cnt == ADDR_LAST) begin
            bit_cnt_n = '0;
            state_n   = ST_DATA;
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
          end
        end
      end

      ST_DATA: begin
        active = 1'b1;
        if (bit_end) begin
          if (bit_cnt == DATA_LAST) begin
            // rx_next already holds the 32nd bit being sampled on this edge.
            data_n    = byte_swap32(rx_next);
            valid_n   = 1'b1;
            bit_cnt_n = '0;
            state_n   = ST_CHECK;
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
          end
        end
      end

      ST_CHECK: begin
        // The flash keeps streaming bytes while csb stays low, so only the
        // directly following word can be served without a new header.
        if (req.dataRequest_enable && (req.dataRequest_address[23:2] == next_idx)) begin
          word_idx_n = req.dataRequest_address[23:2];
          state_n    = ST_DATA;
        end else begin
          csb_n     = 1'b1;
          rel_cnt_n = '0;
          state_n   = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        if (rel_cnt == REL_LAST) begin
          state_n = ST_IDLE;
        end else begin
          rel_cnt_n = rel_cnt + 1'b1;
        end
      end

      default: begin
        state_n = ST_IDLE;
        csb_n   = 1'b1;
      end
    endcase
  end

  assign flash_csb                 = csb_q;
  assign req.dataRequest_data      = data_q;
  assign req.dataRequest_dataValid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_qspi_device.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_qspi_device                                               |
// | Description : Self-checking bench for qspi_device with a behavioural SPI   |
// |               flash (sparse random byte array) and timing expectations     |
// |               derived from the cycle budget of each transaction.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_qspi_device;

  localparam int         CS_HIGH    = 2;
  localparam logic [7:0] CMD        = 8'h03;
  // Cycle number of dataValid, counting the accept cycle as cycle 1.
  localparam int         LAT_NEW    = 1 + 64 * 2 + 1;
  // Cycles from the CHECK/dataValid cycle to the next dataValid when streaming.
  localparam int         LAT_STREAM = 65;

  logic clk        = 1'b0;
  logic rst        = 1'b1;
  logic flash_miso = 1'b0;
  logic flash_csb;
  logic flash_sck;
  logic flash_mosi;

  always #5 clk = ~clk;

  qspi_device_if bus ();

  qspi_device #(
    .CS_HIGH_CYCLES (CS_HIGH),
    .READ_COMMAND   (CMD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (bus),
    .flash_csb  (flash_csb),
    .flash_sck  (flash_sck),
    .flash_mosi (flash_mosi),
    .flash_miso (flash_miso)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- flash model ----------------
  logic [7:0]  mem [logic [23:0]];
  logic [31:0] hdr_q[$];
  logic [31:0] hdr_sr = '0;
  logic [23:0] faddr  = '0;
  logic [7:0]  cur_byte;
  int          fbits = 0;
  int          dbit;
  int          mosi_viol = 0;

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    if (!mem.exists(a)) mem[a] = 8'($urandom);
    return mem[a];
  endfunction

  function automatic logic [31:0] model_word(input logic [23:0] a);
    logic [23:0] base;
    base = {a[23:2], 2'b00};
    return {flash_byte(base + 24'd3), flash_byte(base + 24'd2),
            flash_byte(base + 24'd1), flash_byte(base)};
  endfunction

  always @(negedge flash_csb) fbits = 0;

  always @(posedge flash_sck) begin
    if (flash_csb === 1'b0) begin
      if (fbits < 32) begin
        hdr_sr = {hdr_sr[30:0], flash_mosi};
        fbits++;
        if (fbits == 32) begin
          hdr_q.push_back(hdr_sr);
          faddr = hdr_sr[23:0];
        end
      end else begin
        if (flash_mosi !== 1'b0) mosi_viol++;
        fbits++;
      end
    end
  end

  // Mode 0: the flash shifts out on the falling sck edge.
  always @(negedge flash_sck) begin
    if (flash_csb === 1'b0 && fbits >= 32) begin
      dbit       = fbits - 32;
      cur_byte   = flash_byte(faddr + 24'(dbit / 8));
      flash_miso = cur_byte[7 - (dbit % 8)];
    end
  end

  // ---------------- monitors ----------------
  int   cyc = 0;
  int   valid_cnt = 0;
  int   sig_viol = 0;
  int   high_run = 0;
  int   run_q[$];
  logic prev_csb = 1'b1;
  logic prev_sck = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.dataRequest_dataValid === 1'b1) valid_cnt++;
    if (flash_csb === 1'b1 && flash_sck !== 1'b0) sig_viol++;
    if (flash_csb !== prev_csb && (flash_sck !== 1'b0 || prev_sck !== 1'b0)) sig_viol++;
    if (flash_csb === 1'b1) high_run++;
    else if (flash_csb === 1'b0) begin
      if (high_run > 0) run_q.push_back(high_run);
      high_run = 0;
    end
    prev_csb = flash_csb;
    prev_sck = flash_sck;
  end

  // ---------------- stimulus ----------------
  logic [23:0] burst_q[$];

  // Reads every address in burst_q, keeping enable high between words so
  // each follow-on either streams or restarts depending on its word index.
  task automatic burst();
    int          n;
    int          exp_cyc;
    int          vbase;
    int          hbase;
    int          nonseq;
    bit          ok;
    logic [31:0] exp_hdr[$];
    n      = burst_q.size();
    vbase  = valid_cnt;
    hbase  = hdr_q.size();
    nonseq = 0;
    @(negedge clk);
    bus.dataRequest_address = burst_q[0];
    bus.dataRequest_enable  = 1'b1;
    exp_cyc = cyc + LAT_NEW - 1;
    exp_hdr.push_back({CMD, burst_q[0][23:2], 2'b00});
    for (int i = 0; i < n; i++) begin
      ok = 1'b0;
      while (!ok && cyc <= exp_cyc + 10) begin
        @(negedge clk);
        // Mid-word noise on the request bus must not disturb the transfer.
        if (cyc == exp_cyc - 20) begin
          bus.dataRequest_address = 24'($urandom);
          bus.dataRequest_enable  = 1'($urandom);
        end
        if (bus.dataRequest_dataValid === 1'b1) ok = 1'b1;
      end
      check_eq("valid_cycle", 64'(cyc), 64'(exp_cyc));
      if (!ok) begin
        bus.dataRequest_enable = 1'b0;
        return;
      end
      check_eq("read_data", bus.dataRequest_data, model_word(burst_q[i]));
      if (i == 0) run_q.delete();
      if (i + 1 < n) begin
        bus.dataRequest_address = burst_q[i+1];
        bus.dataRequest_enable  = 1'b1;
        if (burst_q[i+1][23:2] == burst_q[i][23:2] + 22'd1) begin
          exp_cyc = cyc + LAT_STREAM;
        end else begin
          nonseq++;
          exp_cyc = cyc + CS_HIGH + LAT_NEW;
          exp_hdr.push_back({CMD, burst_q[i+1][23:2], 2'b00});
        end
      end else begin
        bus.dataRequest_enable = 1'b0;
      end
    end
    repeat (CS_HIGH + 4) @(negedge clk);
    check_eq("valid_pulses", 64'(valid_cnt - vbase), 64'(n));
    check_eq("csb_idle", flash_csb, 1'b1);
    check_eq("data_hold", bus.dataRequest_data, model_word(burst_q[n-1]));
    check_eq("hdr_count", 64'(hdr_q.size() - hbase), 64'(exp_hdr.size()));
    for (int j = 0; j < exp_hdr.size() && hbase + j < hdr_q.size(); j++)
      check_eq("hdr_bits", hdr_q[hbase+j], exp_hdr[j]);
    check_eq("csb_gaps", 64'(run_q.size()), 64'(nonseq));
    foreach (run_q[j]) check_eq("csb_gap_len", 64'(run_q[j]), 64'(CS_HIGH + 1));
  endtask

  task automatic reset_abort();
    int          t0;
    int          vbase;
    int          hbase;
    @(negedge clk);
    bus.dataRequest_address = 24'($urandom);
    bus.dataRequest_enable  = 1'b1;
    t0    = cyc;
    hbase = hdr_q.size();
    @(negedge clk);
    bus.dataRequest_enable = 1'b0;
    // Cycle 38 is phase A of overall bit 18, i.e. address bit 10.
    while (cyc < t0 + 37) @(negedge clk);
    vbase = valid_cnt;
    rst   = 1'b1;
    @(negedge clk);
    check_eq("abort_csb", flash_csb, 1'b1);
    check_eq("abort_sck", flash_sck, 1'b0);
    check_eq("abort_mosi", flash_mosi, 1'b0);
    check_eq("abort_valid", bus.dataRequest_dataValid, 1'b0);
    check_eq("abort_data", bus.dataRequest_data, 32'h0);
    rst = 1'b0;
    repeat (150) @(negedge clk);
    check_eq("abort_no_valid", 64'(valid_cnt - vbase), 64'd0);
    check_eq("abort_no_hdr", 64'(hdr_q.size()), 64'(hbase));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [23:0] a;
    logic [23:0] nxt;
    int          nw;
    bus.dataRequest_address = '0;
    bus.dataRequest_enable  = 1'b0;
    mem[24'h000100] = 8'h11;
    mem[24'h000101] = 8'h22;
    mem[24'h000102] = 8'h33;
    mem[24'h000103] = 8'h44;

    repeat (3) @(negedge clk);
    check_eq("rst_csb", flash_csb, 1'b1);
    check_eq("rst_sck", flash_sck, 1'b0);
    check_eq("rst_mosi", flash_mosi, 1'b0);
    check_eq("rst_valid", bus.dataRequest_dataValid, 1'b0);
    check_eq("rst_data", bus.dataRequest_data, 32'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Single read with known flash contents.
    burst_q = '{24'h000100};
    burst();
    check_eq("single_word", bus.dataRequest_data, 32'h44332211);
    check_eq("single_hdr", hdr_q[hdr_q.size()-1], 32'h03000100);

    // Streaming, non-sequential restart and array wrap.
    burst_q = '{24'h000100, 24'h000104};
    burst();
    burst_q = '{24'h000100, 24'h000200};
    burst();
    check_eq("restart_hdr", hdr_q[hdr_q.size()-1], 32'h03000200);
    burst_q = '{24'hFFFFFC, 24'h000000};
    burst();

    // Reset in the middle of the address phase, then a normal read.
    reset_abort();
    burst_q = '{24'h000100};
    burst();

    // Random bursts mixing streamed and restarted words.
    for (int r = 0; r < 12; r++) begin
      nw = int'($urandom_range(1, 4));
      a  = 24'($urandom);
      burst_q = '{a};
      for (int k = 1; k < nw; k++) begin
        if ($urandom_range(0, 1) == 1) begin
          nxt = {a[23:2] + 22'd1, 2'($urandom)};
        end else begin
          do nxt = 24'($urandom); while (nxt[23:2] == a[23:2] + 22'd1);
        end
        burst_q.push_back(nxt);
        a = nxt;
      end
      burst();
    end

    check_eq("sck_low_with_csb", 64'(sig_viol), 64'd0);
    check_eq("mosi_low_in_data", 64'(mosi_viol), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
